cory_skid: RTL and testbench
============================

Name: cory_skid

Overview:
- Valid/ready register slice that breaks both handshake paths of the cory valid/ready interface: forward (v/d) and backward (ready).
- Functionally transparent like a plain wire stage: same ordering, same data. Adds 1 cycle of forward latency and no throughput loss.
- Used between cory pipeline blocks where the combinational ready chain or the valid/data chain would limit timing.

Parameters:
- N, 8, data width of i_a_d / o_z_d

Ports:
- clk  input  1  single clock; all state updates on posedge clk
- reset_n  input  1  asynchronous, active-low reset
- i_a_v  input  1  upstream valid
- i_a_d  input  N  upstream data
- o_a_r  output  1  upstream ready; driven directly from a flop
- o_z_v  output  1  downstream valid; driven directly from a flop
- o_z_d  output  N  downstream data; driven directly from a flop
- i_z_r  input  1  downstream ready
- o_cnt  output  2  occupancy 0..2, for debug and verification

Behaviour:
- Interface:
  - One clock, clk.
  - Reset is asynchronous and active-low on reset_n.
  - Every state element clears immediately on reset_n=0, independent of clk.
- Transfers:
  - Upstream transfer: i_a_v & o_a_r at a posedge.
  - Downstream transfer: o_z_v & i_z_r at a posedge.
- Storage:
  - main register (main_v, main_d) drives o_z_v / o_z_d.
  - skid register (skid_v, skid_d) holds one beat.
- States, encoded by {skid_v, main_v}:
  - EMPTY = 00
  - ONE = 01
  - FULL = 11
  - State 10 is illegal and unreachable.
- Output decode:
  - o_a_r = ~skid_v (registered).
  - o_z_v = main_v.
  - o_cnt = main_v + skid_v.
- Transitions:
  - EMPTY, upstream transfer: main <= i_a_d, go to ONE. No transfer: stay.
  - ONE, upstream and downstream transfer in the same cycle: main <= i_a_d, stay in ONE (full throughput).
  - ONE, upstream transfer only: skid <= i_a_d, go to FULL. o_a_r falls next cycle.
  - ONE, downstream transfer only: go to EMPTY.
  - ONE, neither: hold.
  - FULL, downstream transfer: main <= skid_d, go to ONE. o_a_r rises next cycle.
  - FULL, no downstream transfer: hold. o_a_r=0, so no upstream transfer can occur.
- Latency: a beat accepted at edge k can be presented on o_z_v/o_z_d at cycle k+1 at the earliest.
- Ordering: strict FIFO order, depth 2. No beat may be dropped or duplicated.
- Data stability:
  - o_z_d must not change while o_z_v=1 and i_z_r=0.
  - i_a_d is ignored when i_a_v=0.
- Reset values:
  - o_z_v=0, o_z_d=0, o_a_r=1, o_cnt=0.
  - main_d and skid_d = 0.
- Reset mid-operation: all held beats are discarded. Outputs take their reset values asynchronously. The first edge after release behaves as EMPTY.
- No combinational path from any input to any output.
- i_z_r may toggle freely while o_z_v=0; it has no effect.

Decomposition:
- Shared package cory_pkg holds:
  - the state encodings EMPTY/ONE/FULL as localparams;
  - the occupancy width constant (2).
- One sub-module is natural: cory_dff_en, an N-bit register with enable and asynchronous active-low clear.
  - It is instantiated twice: main and skid.
  - The top level holds only the control state machine and the muxes.

Test Plan:
- Reset: hold reset_n=0 with i_a_v=1, i_a_d=8'hA5 -> o_z_v=0, o_a_r=1, o_cnt=0. After release, 8'hA5 appears on o_z_d exactly 1 cycle after the first accepting edge.
- Streaming: i_z_r=1 constant, send 0x00..0xFF back-to-back -> o_a_r stays 1, o_z_d outputs 0x00..0xFF in order one per cycle, o_cnt=1 steady.
- Backpressure fill: i_z_r=0, send 0x11, 0x22, 0x33 -> o_cnt goes 1 then 2. o_a_r=0 after 2 beats, so 0x33 is held upstream. o_z_d stays 0x11 throughout.
- Drain from FULL: continue the previous case with i_z_r=1 -> output sequence 0x11, 0x22, 0x33 with no gap. o_a_r returns to 1 one cycle after the first downstream transfer.
- Random stress: 10k beats with randomized i_a_v / i_z_r at 50% -> a scoreboard shows an in-order exact match, o_z_d stable under stall, and {skid_v,main_v} never equal to 10.
- Async reset mid-stream: assert reset_n=0 between edges while FULL -> o_z_v and o_a_r change immediately to 0 and 1, held beats are lost, and the next beat sent passes normally.

Source files
------------

// File: rtl/cory_pkg.sv
// Shared constants for the cory valid/ready building blocks: skid-slice state
// encodings ({skid_v, main_v}) and the occupancy counter width.
package cory_pkg;

  localparam logic [1:0] ST_EMPTY = 2'b00;
  localparam logic [1:0] ST_ONE   = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b11;

  localparam int CNT_W = 2;

endpackage : cory_pkg

// File: rtl/cory_dff_en.sv
// N-bit register with load enable and asynchronous active-low clear.
module cory_dff_en #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q_o <= '0;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule : cory_dff_en

// File: rtl/cory_skid.sv
// Two-entry valid/ready register slice: every output comes straight from a flop,
// cutting both the forward valid/data path and the backward ready path.
module cory_skid
  import cory_pkg::*;
#(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_a_v,
  input  logic [N-1:0]     i_a_d,
  output logic             o_a_r,
  output logic             o_z_v,
  output logic [N-1:0]     o_z_d,
  input  logic             i_z_r,
  output logic [CNT_W-1:0] o_cnt
);

  logic [1:0]   state_q, state_d;
  logic         a_r_q;
  logic         main_v, skid_v;
  logic         up_xfer, dn_xfer;
  logic         main_en, main_from_skid, skid_en;
  logic [N-1:0] main_d, skid_q, main_q;

  assign main_v  = state_q[0];
  assign skid_v  = state_q[1];
  assign up_xfer = i_a_v & a_r_q;
  assign dn_xfer = main_v & i_z_r;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d        = state_q;
    main_en        = 1'b0;
    main_from_skid = 1'b0;
    skid_en        = 1'b0;
    case (state_q)
      ST_EMPTY: begin
        if (up_xfer) begin
          main_en = 1'b1;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (up_xfer && dn_xfer) begin
          main_en = 1'b1;
        end else if (up_xfer) begin
          skid_en = 1'b1;
          state_d = ST_FULL;
        end else if (dn_xfer) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // Ready is low here, so only the downstream side can move.
        if (dn_xfer) begin
          main_en        = 1'b1;
          main_from_skid = 1'b1;
          state_d        = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign main_d = main_from_skid ? skid_q : i_a_d;

  // Ready is a dedicated flop holding ~skid_v so it leaves the block without logic.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_EMPTY;
      a_r_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      a_r_q   <= ~state_d[1];
    end
  end

  cory_dff_en #(.N(N)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (main_en),
    .d_i     (main_d),
    .q_o     (main_q)
  );

  cory_dff_en #(.N(N)) u_skid (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (skid_en),
    .d_i     (i_a_d),
    .q_o     (skid_q)
  );

  assign o_a_r = a_r_q;
  assign o_z_v = main_v;
  assign o_z_d = main_q;
  assign o_cnt = CNT_W'(main_v) + CNT_W'(skid_v);

endmodule : cory_skid

// File: tb/tb_cory_skid.sv
// Scoreboard bench for cory_skid: a depth-2 FIFO reference model predicts
// handshakes and data; a negedge monitor compares every cycle.
module tb_cory_skid;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         i_a_v = 1'b0;
  logic [N-1:0] i_a_d = '0;
  logic         o_a_r;
  logic         o_z_v;
  logic [N-1:0] o_z_d;
  logic         i_z_r = 1'b0;
  logic [1:0]   o_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [N-1:0] exp_q[$];
  logic         last_up = 1'b0;
  logic         zr_fix  = 1'b0;
  logic         zr_rand = 1'b0;

  cory_skid #(.N(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .i_a_v   (i_a_v),
    .i_a_d   (i_a_d),
    .o_a_r   (o_a_r),
    .o_z_v   (o_z_v),
    .o_z_d   (o_z_d),
    .i_z_r   (i_z_r),
    .o_cnt   (o_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an ideal 2-deep FIFO updated at each edge from the driven inputs.
  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        exp_q.delete();
        last_up = 1'b0;
      end else begin
        logic up, dn;
        up = i_a_v && (exp_q.size() < 2);
        dn = (exp_q.size() > 0) && i_z_r;
        if (dn) void'(exp_q.pop_front());
        if (up) exp_q.push_back(i_a_d);
        last_up = up;
      end
    end
  end

  // Monitor: handshake/occupancy every cycle, and head-of-queue data whenever valid.
  initial begin
    forever begin
      @(negedge clk);
      check("o_a_r", 32'(o_a_r), 32'(exp_q.size() != 2));
      check("o_z_v", 32'(o_z_v), 32'(exp_q.size() != 0));
      check("o_cnt", 32'(o_cnt), 32'(exp_q.size()));
      if (exp_q.size() > 0) check("o_z_d", 32'(o_z_d), 32'(exp_q[0]));
    end
  end

  // Downstream ready generator; runs 2 time units after the edge, after the driver.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      i_z_r = zr_rand ? 1'($urandom_range(0, 1)) : zr_fix;
    end
  end

  task automatic send_beat(input logic [N-1:0] d);
    int n = 0;
    i_a_v = 1'b1;
    i_a_d = d;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!last_up && n < 64);
    if (!last_up) check("send_timeout", 32'(n), 32'(0));
    i_a_v = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    zr_rand = 1'b0;
    zr_fix  = 1'b1;
    i_a_v   = 1'b0;
    while (exp_q.size() != 0 && n < 64) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) check("drain_timeout", 32'(exp_q.size()), 32'(0));
  endtask

  initial begin
    // Reset held with a valid beat pending upstream.
    i_a_v = 1'b1;
    i_a_d = 8'hA5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_z_v", 32'(o_z_v), 32'(0));
    check("rst_a_r", 32'(o_a_r), 32'(1));
    check("rst_cnt", 32'(o_cnt), 32'(0));
    check("rst_z_d", 32'(o_z_d), 32'(0));
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_accept", 32'(last_up), 32'(1));
    check("first_z_v", 32'(o_z_v), 32'(1));
    check("first_z_d", 32'(o_z_d), 32'h A5);
    i_a_v = 1'b0;
    drain();

    // Streaming at full throughput.
    zr_fix = 1'b1;
    for (int i = 0; i < 256; i++) send_beat(8'(i));
    drain();

    // Backpressure fill: two beats fit, the third waits upstream.
    zr_fix = 1'b0;
    @(posedge clk);
    #1;
    send_beat(8'h11);
    send_beat(8'h22);
    check("bp_a_r", 32'(o_a_r), 32'(0));
    check("bp_cnt", 32'(o_cnt), 32'(2));
    i_a_v = 1'b1;
    i_a_d = 8'h33;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("bp_hold_d", 32'(o_z_d), 32'h11);
      check("bp_no_accept", 32'(last_up), 32'(0));
    end
    // Drain from FULL; the pending 0x33 is taken once ready returns.
    zr_fix = 1'b1;
    send_beat(8'h33);
    drain();

    // Random stress with garbage data on idle cycles.
    zr_rand = 1'b1;
    for (int b = 0; b < 10000; b++) begin
      while ($urandom_range(0, 1) == 0) begin
        i_a_v = 1'b0;
        i_a_d = 8'($urandom);
        @(posedge clk);
        #1;
      end
      send_beat(8'($urandom));
    end
    drain();

    // Asynchronous reset while FULL, applied between edges.
    zr_fix = 1'b0;
    @(posedge clk);
    #1;
    send_beat(8'h5A);
    send_beat(8'hC3);
    check("pre_rst_cnt", 32'(o_cnt), 32'(2));
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_z_v", 32'(o_z_v), 32'(0));
    check("arst_a_r", 32'(o_a_r), 32'(1));
    check("arst_cnt", 32'(o_cnt), 32'(0));
    check("arst_z_d", 32'(o_z_d), 32'(0));
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    zr_fix = 1'b1;
    send_beat(8'h7E);
    check("post_rst_z_d", 32'(o_z_d), 32'h7E);
    drain();
    repeat (2) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_cory_skid
